axil_led_bank: RTL and testbench

//  AXI4-Lite slave exposing N_CH independent LED channels, each with a static or blink mode.
//  A shared blink timer with a programmable period drives the blink phase.

---
 rtl/led_bank_pkg.sv | 14 +
 rtl/axil_led_bank_if.sv | 32 +++
 rtl/led_bank_blink_timer.sv | 33 +++
 rtl/axil_led_bank.sv | 211 +++++++++++++++++++++
 tb/tb_axil_led_bank.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_bank_pkg.sv
// Shared constants and FSM state types for the AXI4-Lite LED bank.
package led_bank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int OFF_PERIOD = 'h80;
    localparam int OFF_STAT   = 'h84;
    localparam int CH_STRIDE  = 8;

    typedef enum logic [0:0] {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic [0:0] {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/axil_led_bank_if.sv
// AXI4-Lite bus bundle between the PS/VIP master and the LED bank slave.
interface axil_led_bank_if #(parameter int ADDR_W = 8);

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/led_bank_blink_timer.sv
// Shared blink timer: counts 0..period-1 and toggles phase on each wrap.
module led_bank_blink_timer #(
    parameter int CNT_W = 24
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [CNT_W-1:0] period,
    input  logic             period_wr,
    output logic             phase,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt;

    // wrap marks the edge on which phase toggles; a period write restarts instead
    assign wrap = (period != '0) && !period_wr && (cnt == period - CNT_W'(1));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (period_wr || period == '0) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (wrap) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/axil_led_bank.sv
// AXI4-Lite LED bank: N_CH channels with static/blink modes and a shared blink timer.
// Optional LED_BANK_PHASE_IRQ_EN adds STAT at 0x84 and a level irq on phase wraps.
module axil_led_bank
    import led_bank_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int N_CH   = 4,
    parameter int LED_W  = 4,
    parameter int CNT_W  = 24
) (
    input  logic                  aclk,
    input  logic                  areset,
    axil_led_bank_if.slave        s_axi,
    output logic [N_CH*LED_W-1:0] led_o
`ifdef LED_BANK_PHASE_IRQ_EN
    ,
    output logic                  irq
`endif
);

    function automatic logic is_chan(input logic [ADDR_W-1:0] a);
        return ((a >> 7) == '0) && (int'(a[6:3]) < N_CH);
    endfunction

    function automatic logic is_off(input logic [ADDR_W-1:0] a, input int off);
        return (a & ~ADDR_W'(3)) == ADDR_W'(off);
    endfunction

    function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] d,
                                               input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = s[b] ? d[b*8 +: 8] : old[b*8 +: 8];
        return r;
    endfunction

    wr_state_t        wr_state;
    rd_state_t        rd_state;
    logic [LED_W-1:0] ctrl_val [N_CH];
    logic [N_CH-1:0]  ctrl_blink;
    logic [31:0]      ctrl_word [N_CH];
    logic [CNT_W-1:0] period;
    logic             phase;
    logic             wr_fire, wr_period, wr_stat, wr_err;
    logic [N_CH-1:0]  wr_ch_sel;
    logic [31:0]      rd_word;
    logic             rd_err;
`ifdef LED_BANK_PHASE_IRQ_EN
    logic             phase_wrap;
    logic             stat_flag;
`else
    logic             phase_wrap_unused;
`endif

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            ctrl_word[c]     = 32'(ctrl_val[c]);
            ctrl_word[c][31] = ctrl_blink[c];
        end
    end

    // Write decode: ready is asserted only while both valids are held, so the edge with ready high is the handshake
    assign wr_fire = (wr_state == W_IDLE) && s_axi.awready && s_axi.awvalid && s_axi.wvalid;

    always_comb begin
        for (int c = 0; c < N_CH; c++)
            wr_ch_sel[c] = is_chan(s_axi.awaddr) && !s_axi.awaddr[2] && (s_axi.awaddr[6:3] == 4'(c));
        wr_period = is_off(s_axi.awaddr, OFF_PERIOD);
`ifdef LED_BANK_PHASE_IRQ_EN
        wr_stat   = is_off(s_axi.awaddr, OFF_STAT);
`else
        wr_stat   = 1'b0;
`endif
        wr_err    = !(|wr_ch_sel) && !wr_period && !wr_stat;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_state      <= W_IDLE;
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b0;
            s_axi.bvalid  <= 1'b0;
            s_axi.bresp   <= RESP_OKAY;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (wr_fire) begin
                        s_axi.awready <= 1'b0;
                        s_axi.wready  <= 1'b0;
                        s_axi.bvalid  <= 1'b1;
                        s_axi.bresp   <= wr_err ? RESP_SLVERR : RESP_OKAY;
                        wr_state      <= W_RESP;
                    end else begin
                        s_axi.awready <= s_axi.awvalid && s_axi.wvalid && !s_axi.awready;
                        s_axi.wready  <= s_axi.awvalid && s_axi.wvalid && !s_axi.awready;
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        s_axi.bvalid <= 1'b0;
                        wr_state     <= W_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int c = 0; c < N_CH; c++) ctrl_val[c] <= '0;
            ctrl_blink <= '0;
            period     <= '0;
        end else if (wr_fire) begin
            for (int c = 0; c < N_CH; c++) begin
                if (wr_ch_sel[c]) begin
                    ctrl_val[c]   <= LED_W'(apply_strb(ctrl_word[c], s_axi.wdata, s_axi.wstrb));
                    ctrl_blink[c] <= s_axi.wstrb[3] ? s_axi.wdata[31] : ctrl_blink[c];
                end
            end
            if (wr_period)
                period <= CNT_W'(apply_strb(32'(period), s_axi.wdata, s_axi.wstrb));
        end
    end

    led_bank_blink_timer #(.CNT_W(CNT_W)) u_timer (
        .aclk      (aclk),
        .areset    (areset),
        .period    (period),
        .period_wr (wr_fire && wr_period),
        .phase     (phase),
`ifdef LED_BANK_PHASE_IRQ_EN
        .wrap      (phase_wrap)
`else
        .wrap      (phase_wrap_unused)
`endif
    );

`ifdef LED_BANK_PHASE_IRQ_EN
    // Set beats a same-cycle clear so no wrap is ever lost
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            stat_flag <= 1'b0;
        else if (phase_wrap && |ctrl_blink)
            stat_flag <= 1'b1;
        else if (wr_fire && wr_stat && s_axi.wstrb[0] && s_axi.wdata[0])
            stat_flag <= 1'b0;
    end

    assign irq = stat_flag;
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            led_o <= '0;
        else
            for (int c = 0; c < N_CH; c++)
                led_o[c*LED_W +: LED_W] <= (ctrl_blink[c] && !phase) ? '0 : ctrl_val[c];
    end

    // Read decode samples live registers, so a same-edge write is seen only by later reads
    always_comb begin
        rd_word = '0;
        rd_err  = 1'b1;
        for (int c = 0; c < N_CH; c++) begin
            if (is_chan(s_axi.araddr) && s_axi.araddr[6:3] == 4'(c)) begin
                rd_err  = 1'b0;
                rd_word = s_axi.araddr[2] ? 32'(led_o[c*LED_W +: LED_W]) : ctrl_word[c];
            end
        end
        if (is_off(s_axi.araddr, OFF_PERIOD)) begin
            rd_err  = 1'b0;
            rd_word = 32'(period);
        end
`ifdef LED_BANK_PHASE_IRQ_EN
        if (is_off(s_axi.araddr, OFF_STAT)) begin
            rd_err  = 1'b0;
            rd_word = {31'b0, stat_flag};
        end
`endif
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rd_state      <= R_IDLE;
            s_axi.arready <= 1'b0;
            s_axi.rvalid  <= 1'b0;
            s_axi.rdata   <= '0;
            s_axi.rresp   <= RESP_OKAY;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (s_axi.arready && s_axi.arvalid) begin
                        s_axi.arready <= 1'b0;
                        s_axi.rvalid  <= 1'b1;
                        s_axi.rdata   <= rd_word;
                        s_axi.rresp   <= rd_err ? RESP_SLVERR : RESP_OKAY;
                        rd_state      <= R_DATA;
                    end else begin
                        s_axi.arready <= s_axi.arvalid && !s_axi.arready;
                    end
                end
                R_DATA: begin
                    if (s_axi.rready) begin
                        s_axi.rvalid <= 1'b0;
                        rd_state     <= R_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_led_bank.sv
// Directed, table-driven bench for axil_led_bank (LED_BANK_PHASE_IRQ_EN selects the irq checks).
module tb_axil_led_bank;

    localparam int ADDR_W = 8;
    localparam int N_CH   = 4;
    localparam int LED_W  = 4;
    localparam int CNT_W  = 24;
    localparam int TMO    = 30;
`ifdef LED_BANK_PHASE_IRQ_EN
    localparam logic [1:0] STAT_RESP = 2'b00;
`else
    localparam logic [1:0] STAT_RESP = 2'b10;
`endif

    logic aclk   = 1'b0;
    logic areset = 1'b1;
    logic [N_CH*LED_W-1:0] led_o;
`ifdef LED_BANK_PHASE_IRQ_EN
    logic irq;
`endif

    always #5 aclk = ~aclk;

    axil_led_bank_if #(.ADDR_W(ADDR_W)) bus ();

    axil_led_bank #(.ADDR_W(ADDR_W), .N_CH(N_CH), .LED_W(LED_W), .CNT_W(CNT_W)) dut (
        .aclk   (aclk),
        .areset (areset),
        .s_axi  (bus),
        .led_o  (led_o)
`ifdef LED_BANK_PHASE_IRQ_EN
        ,
        .irq    (irq)
`endif
    );

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s timeout after %0d cycles", name, TMO);
    endtask

    // Presents AW+W and returns 1ns after the edge on which the write lands.
    task automatic write_start(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        bus.awaddr  = a;
        bus.wdata   = d;
        bus.wstrb   = s;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        @(negedge aclk);
        while (!(bus.awready && bus.wready) && n < TMO) begin
            @(negedge aclk);
            n++;
        end
        if (n >= TMO) timeout("aw_handshake");
        @(posedge aclk);
        #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
    endtask

    task automatic write_resp(output logic [1:0] resp);
        int n = 0;
        @(negedge aclk);
        while (!bus.bvalid && n < TMO) begin
            @(negedge aclk);
            n++;
        end
        if (n >= TMO) timeout("b_response");
        resp = bus.bresp;
        @(posedge aclk);
        #1;
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        write_start(a, d, s);
        write_resp(resp);
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        @(negedge aclk);
        while (!bus.arready && n < TMO) begin
            @(negedge aclk);
            n++;
        end
        if (n >= TMO) timeout("ar_handshake");
        @(posedge aclk);
        #1;
        bus.arvalid = 1'b0;
        n = 0;
        @(negedge aclk);
        while (!bus.rvalid && n < TMO) begin
            @(negedge aclk);
            n++;
        end
        if (n >= TMO) timeout("r_data");
        data = bus.rdata;
        resp = bus.rresp;
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rsp;
        logic [3:0]  exp_led;

        vecs[0]  = '{1'b0, 8'h04, 32'h0,         4'h0, 2'b00, 32'h0000_0003};
        vecs[1]  = '{1'b0, 8'h00, 32'h0,         4'h0, 2'b00, 32'h0000_0003};
        vecs[2]  = '{1'b1, 8'h08, 32'hFFFF_FFFF, 4'h1, 2'b00, 32'h0};
        vecs[3]  = '{1'b0, 8'h08, 32'h0,         4'h0, 2'b00, 32'h0000_000F};
        vecs[4]  = '{1'b0, 8'h0C, 32'h0,         4'h0, 2'b00, 32'h0000_000F};
        vecs[5]  = '{1'b1, 8'h40, 32'h1,         4'hF, 2'b10, 32'h0};
        vecs[6]  = '{1'b1, 8'h04, 32'h7,         4'hF, 2'b10, 32'h0};
        vecs[7]  = '{1'b0, 8'h00, 32'h0,         4'h0, 2'b00, 32'h0000_0003};
        vecs[8]  = '{1'b0, 8'h04, 32'h0,         4'h0, 2'b00, 32'h0000_0003};
        vecs[9]  = '{1'b0, 8'h7C, 32'h0,         4'h0, 2'b10, 32'h0};
        vecs[10] = '{1'b0, 8'h20, 32'h0,         4'h0, 2'b10, 32'h0};
        vecs[11] = '{1'b1, 8'h18, 32'h8000_00AB, 4'h8, 2'b00, 32'h0};
        vecs[12] = '{1'b0, 8'h18, 32'h0,         4'h0, 2'b00, 32'h8000_0000};
        vecs[13] = '{1'b0, 8'h1C, 32'h0,         4'h0, 2'b00, 32'h0};
        vecs[14] = '{1'b1, 8'h80, 32'h1234_5678, 4'hF, 2'b00, 32'h0};
        vecs[15] = '{1'b0, 8'h83, 32'h0,         4'h0, 2'b00, 32'h0034_5678};
        vecs[16] = '{1'b1, 8'h80, 32'h0,         4'hF, 2'b00, 32'h0};
        vecs[17] = '{1'b0, 8'h80, 32'h0,         4'h0, 2'b00, 32'h0};
        vecs[18] = '{1'b0, 8'h84, 32'h0,         4'h0, STAT_RESP, 32'h0};
        vecs[19] = '{1'b1, 8'h10, 32'h0000_000A, 4'h1, 2'b00, 32'h0};
        vecs[20] = '{1'b0, 8'h14, 32'h0,         4'h0, 2'b00, 32'h0000_000A};

        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b1; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;

        // Reset state
        repeat (10) @(negedge aclk);
        check("rst_led", 32'(led_o), 32'h0);
        check("rst_bvalid", 32'(bus.bvalid), 32'h0);
        check("rst_rvalid", 32'(bus.rvalid), 32'h0);
        check("rst_awready", 32'(bus.awready), 32'h0);
        check("rst_arready", 32'(bus.arready), 32'h0);
        areset = 1'b0;
        @(posedge aclk);
        #1;
        axi_read(8'h80, rd, rsp);
        check("rst_period_data", rd, 32'h0);
        check("rst_period_resp", 32'(rsp), 32'h0);

        // CTRL_0 write and one-cycle LED latency
        write_start(8'h00, 32'h3, 4'hF);
        @(negedge aclk);
        check("led_before_latency", 32'(led_o[3:0]), 32'h0);
        check("w0_bvalid", 32'(bus.bvalid), 32'h1);
        check("w0_bresp", 32'(bus.bresp), 32'h0);
        @(posedge aclk);
        #1;
        @(negedge aclk);
        check("led_after_latency", 32'(led_o[3:0]), 32'h3);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, rsp);
                check($sformatf("vec%0d_bresp", i), 32'(rsp), 32'(vecs[i].resp));
            end else begin
                axi_read(vecs[i].addr, rd, rsp);
                check($sformatf("vec%0d_rresp", i), 32'(rsp), 32'(vecs[i].resp));
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
            end
        end

        // Blink: CTRL_0 set while PERIOD=0, then PERIOD=4 restarts the phase at 1
        axi_write(8'h00, 32'h8000_0005, 4'hF, rsp);
        check("blink_ctrl_bresp", 32'(rsp), 32'h0);
        write_start(8'h80, 32'h4, 4'hF);
        for (int i = 0; i < 17; i++) begin
            @(negedge aclk);
            exp_led = (i == 0 || ((i - 1) / 4) % 2 == 0) ? 4'h5 : 4'h0;
            check($sformatf("blink_t%0d", i), 32'(led_o[3:0]), 32'(exp_led));
        end

        // Backpressure on B: response holds and no second AW is taken
        bus.bready = 1'b0;
        write_start(8'h08, 32'h1, 4'hF);
        bus.awaddr  = 8'h10;
        bus.wdata   = 32'h7;
        bus.wstrb   = 4'hF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            check($sformatf("bp_bvalid_%0d", i), 32'(bus.bvalid), 32'h1);
            check($sformatf("bp_awready_%0d", i), 32'(bus.awready), 32'h0);
        end
        bus.bready = 1'b1;
        write_resp(rsp);
        check("bp_first_bresp", 32'(rsp), 32'h0);
        write_start(8'h10, 32'h7, 4'hF);
        write_resp(rsp);
        check("bp_second_bresp", 32'(rsp), 32'h0);
        axi_read(8'h10, rd, rsp);
        check("bp_second_data", rd, 32'h7);
        axi_read(8'h08, rd, rsp);
        check("bp_first_data", rd, 32'h1);

        // Reset asserted while read data waits for rready
        bus.rready  = 1'b0;
        bus.araddr  = 8'h08;
        bus.arvalid = 1'b1;
        begin
            int n = 0;
            @(negedge aclk);
            while (!bus.arready && n < TMO) begin
                @(negedge aclk);
                n++;
            end
            if (n >= TMO) timeout("rst_rd_ar");
            @(posedge aclk);
            #1;
            bus.arvalid = 1'b0;
            @(negedge aclk);
            check("rst_rd_rvalid_before", 32'(bus.rvalid), 32'h1);
            check("rst_rd_data_before", bus.rdata, 32'h1);
        end
        #2;
        areset = 1'b1;
        #1;
        check("rst_rd_rvalid_after", 32'(bus.rvalid), 32'h0);
        check("rst_rd_led_after", 32'(led_o), 32'h0);
        repeat (3) @(negedge aclk);
        areset     = 1'b0;
        bus.rready = 1'b1;
        @(posedge aclk);
        #1;
        axi_read(8'h08, rd, rsp);
        check("post_rst_ctrl1", rd, 32'h0);

`ifdef LED_BANK_PHASE_IRQ_EN
        axi_write(8'h00, 32'h8000_0005, 4'hF, rsp);
        axi_write(8'h84, 32'h1, 4'hF, rsp);
        check("irq_clear_bresp", 32'(rsp), 32'h0);
        check("irq_idle", 32'(irq), 32'h0);
        write_start(8'h80, 32'h2, 4'hF);
        @(negedge aclk);
        check("irq_t0", 32'(irq), 32'h0);
        @(negedge aclk);
        check("irq_t1", 32'(irq), 32'h0);
        @(negedge aclk);
        check("irq_t2", 32'(irq), 32'h1);
        @(posedge aclk);
        #1;
        axi_read(8'h84, rd, rsp);
        check("stat_set", rd, 32'h1);
        axi_write(8'h80, 32'h0, 4'hF, rsp);
        axi_write(8'h84, 32'h1, 4'hF, rsp);
        @(negedge aclk);
        check("irq_cleared", 32'(irq), 32'h0);
        axi_read(8'h84, rd, rsp);
        check("stat_cleared", rd, 32'h0);
`else
        axi_write(8'h84, 32'h1, 4'hF, rsp);
        check("stat_unmapped_bresp", 32'(rsp), 32'h2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
